// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that sequences each instruction
// over 2-5 cycles on a shared memory/ALU datapath.
// Parameters:
//   EN_ADDI - addi (op 001000) supported; otherwise decoded as illegal
//   EN_JUMP - j (op 000010) supported; otherwise decoded as illegal
//   MEM_HS  - memory states wait on mem_ready; when 0, mem_ready is ignored
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   op, funct           - instruction register fields
//   zero                - ALU zero flag (qualifies PCEn in BEQ)
//   mem_ready           - memory access completes this cycle
//   IorD .. RegWrite    - datapath mux selects and write enables (combinational)
//   illegal_op          - one-cycle pulse in DECODE for an unsupported opcode
//   state               - current state encoding, for debug
module mips_multicycle_ctrl #(
    parameter bit EN_ADDI = 1'b1,
    parameter bit EN_JUMP = 1'b1,
    parameter bit MEM_HS  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCEn,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYP = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    state_t     cur;
    state_t     nxt;
    logic       rdy;
    logic       op_legal;
    logic [1:0] aluop;
    logic       pcwrite;
    logic       branch;

    // Memory handshake; tied high when the datapath has fixed-latency memory.
    assign rdy = MEM_HS ? mem_ready : 1'b1;

    assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYP) ||
                      (op == OP_BEQ) || (EN_ADDI && (op == OP_ADDI)) ||
                      (EN_JUMP && (op == OP_J));

    assign state = cur;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= S_FETCH;
        end else begin
            cur <= nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:  nxt = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                nxt = S_FETCH;
                if ((op == OP_LW) || (op == OP_SW)) nxt = S_MEMADR;
                else if (op == OP_RTYP)             nxt = S_EXEC;
                else if (op == OP_BEQ)              nxt = S_BEQ;
                else if (EN_ADDI && (op == OP_ADDI)) nxt = S_ADDIEX;
                else if (EN_JUMP && (op == OP_J))    nxt = S_JUMP;
            end
            S_MEMADR: nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = rdy ? S_MEMWB : S_MEMRD;
            S_MEMWB:  nxt = S_FETCH;
            S_MEMWR:  nxt = rdy ? S_FETCH : S_MEMWR;
            S_EXEC:   nxt = S_ALUWB;
            S_ALUWB:  nxt = S_FETCH;
            S_BEQ:    nxt = S_FETCH;
            S_ADDIEX: nxt = S_ADDIWB;
            S_ADDIWB: nxt = S_FETCH;
            S_JUMP:   nxt = S_FETCH;
            default:  nxt = S_FETCH;
        endcase
    end

    // Output decode: Moore outputs per state, ALU decode, then reset gating.
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCEn       = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b010;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        illegal_op = 1'b0;
        aluop      = 2'b00;
        pcwrite    = 1'b0;
        branch     = 1'b0;

        case (cur)
            S_FETCH: begin
                ALUSrcB = 2'b01;
                IRWrite = rdy;
                pcwrite = rdy;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                illegal_op = ~op_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            // Strobe is held for the whole wait so memory sees a stable request.
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 1'b1;
                aluop   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase

        case (aluop)
            2'b01: ALUControl = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default:   ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase

        PCEn = pcwrite | (branch & zero);

        // No architectural side effect may leak out while reset is held.
        if (rst) begin
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            PCEn       = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                   S_MEMWB = 4, S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7,
                   S_BEQ = 8, S_ADDIEX = 9, S_ADDIWB = 10, S_JUMP = 11;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_R = 6'b000000, OP_BEQ = 6'b000100,
                           OP_ADDI = 6'b001000, OP_J = 6'b000010;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcen;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] aluctl;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       illegal;
    } obs_t;

    typedef struct {
        int cycles, irw, rw, mw, pcen, ill, ill_dec;
        int alu_exec, pcsrc_beq, regdst_wb, memtoreg_wb;
        int seq_bad, timeout, m_mw, model_done;
    } stats_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       z;
        int cyc, rw, mw, pcen, ill, alu;
    } vec_t;

    typedef int iq_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    obs_t       obs [3];
    obs_t       ob;
    int         sel;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // Instance 0: full config; 1: EN_JUMP=0; 2: MEM_HS=0.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       iord, memwrite, irwrite, pcen, alusrca, regdst, memtoreg, regwrite, illegal;
        logic [1:0] pcsrc, alusrcb;
        logic [2:0] aluctl;
        logic [3:0] st;
        mips_multicycle_ctrl #(
            .EN_ADDI(1'b1),
            .EN_JUMP(g != 1),
            .MEM_HS (g != 2)
        ) u_dut (
            .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
            .mem_ready(mem_ready), .IorD(iord), .MemWrite(memwrite),
            .IRWrite(irwrite), .PCEn(pcen), .PCSrc(pcsrc), .ALUSrcA(alusrca),
            .ALUSrcB(alusrcb), .ALUControl(aluctl), .RegDst(regdst),
            .MemtoReg(memtoreg), .RegWrite(regwrite), .illegal_op(illegal),
            .state(st)
        );
        assign obs[g] = {st, iord, memwrite, irwrite, pcen, pcsrc, alusrca,
                         alusrcb, aluctl, regdst, memtoreg, regwrite, illegal};
    end

    always_comb ob = obs[sel];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit legal_for(input logic [5:0] o, input int inst);
        return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_BEQ) ||
               (o == OP_ADDI) || ((o == OP_J) && (inst != 1));
    endfunction

    // Architectural state path of one instruction, taken from the transition rules.
    function automatic iq_t seq_of(input logic [5:0] o, input int inst);
        iq_t q;
        q.push_back(S_FETCH);
        q.push_back(S_DECODE);
        if (!legal_for(o, inst)) return q;
        case (o)
            OP_LW:   begin q.push_back(S_MEMADR); q.push_back(S_MEMRD); q.push_back(S_MEMWB); end
            OP_SW:   begin q.push_back(S_MEMADR); q.push_back(S_MEMWR); end
            OP_R:    begin q.push_back(S_EXEC); q.push_back(S_ALUWB); end
            OP_BEQ:  q.push_back(S_BEQ);
            OP_ADDI: begin q.push_back(S_ADDIEX); q.push_back(S_ADDIWB); end
            default: q.push_back(S_JUMP);
        endcase
        return q;
    endfunction

    function automatic int alu_ref(input logic [5:0] f);
        case (f)
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return 2;
        endcase
    endfunction

    function automatic bit is_wait(input int s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

    // Runs one instruction from FETCH back to FETCH. mode 0: mem_ready=1,
    // 1: random stalls, 2: three stall cycles in each waiting state.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int mode, output stats_t s);
        iq_t q;
        int  idx = 0;
        int  stl = 0;
        bit  left = 0;
        bit  mr;
        int  e;
        s = '{default: 0};
        q = seq_of(o, sel);
        op = o; funct = f; zero = z;
        for (int c = 0; c < 64; c++) begin
            e  = (idx < q.size()) ? q[idx] : -1;
            mr = 1'b1;
            if (e >= 0 && is_wait(e) && stl < 3) begin
                if (mode == 2)      mr = 1'b0;
                else if (mode == 1) mr = ($urandom_range(0, 2) != 0);
            end
            mem_ready = mr;
            #2;
            s.cycles++;
            if (int'(ob.st) != e) s.seq_bad++;
            s.irw  += int'(ob.irwrite);
            s.rw   += int'(ob.regwrite);
            s.mw   += int'(ob.memwrite);
            s.pcen += int'(ob.pcen);
            s.ill  += int'(ob.illegal);
            if (e == S_DECODE) s.ill_dec = int'(ob.illegal);
            if (e == S_EXEC)   s.alu_exec = int'(ob.aluctl);
            if (e == S_BEQ)    s.pcsrc_beq = int'(ob.pcsrc);
            if (e == S_MEMWB || e == S_ALUWB || e == S_ADDIWB) begin
                s.regdst_wb   = int'(ob.regdst);
                s.memtoreg_wb = int'(ob.memtoreg);
            end
            if (e >= 0) begin
                if (e == S_MEMWR) s.m_mw++;
                if (is_wait(e) && sel != 2 && !mr) stl++;
                else begin idx++; stl = 0; end
            end
            @(posedge clk); #1;
            if (int'(ob.st) != S_FETCH) left = 1'b1;
            else if (left) break;
        end
        s.timeout    = !(left && int'(ob.st) == S_FETCH);
        s.model_done = (idx == q.size());
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   tbl[$];
        stats_t s, s2;
        logic [5:0] ro, rf;
        logic       rz;
        logic [5:0] fl [6];
        int         kind, exp_rw, exp_pcen;
        bit         lg;

        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011011};
        sel = 0; rst = 1'b1; op = OP_R; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

        // Reset: enables forced low while rst high, even with mem_ready=1 in FETCH.
        @(posedge clk); #1;
        #1;
        chk("rst_state_fetch", int'(ob.st), S_FETCH);
        chk("rst_irwrite_gated", int'(ob.irwrite), 0);
        chk("rst_pcen_gated", int'(ob.pcen), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_irwrite", int'(ob.irwrite), 1);

        // Table of single instructions with mem_ready tied high.
        tbl.push_back('{OP_LW,   6'd0,      1'b0, 5, 1, 0, 1, 0, -1});
        tbl.push_back('{OP_SW,   6'd0,      1'b0, 4, 0, 1, 1, 0, -1});
        tbl.push_back('{OP_R,    6'b100000, 1'b0, 4, 1, 0, 1, 0, 2});
        tbl.push_back('{OP_R,    6'b100010, 1'b0, 4, 1, 0, 1, 0, 6});
        tbl.push_back('{OP_R,    6'b100100, 1'b0, 4, 1, 0, 1, 0, 0});
        tbl.push_back('{OP_R,    6'b100101, 1'b0, 4, 1, 0, 1, 0, 1});
        tbl.push_back('{OP_R,    6'b101010, 1'b0, 4, 1, 0, 1, 0, 7});
        tbl.push_back('{OP_R,    6'b000111, 1'b0, 4, 1, 0, 1, 0, 2});
        tbl.push_back('{OP_BEQ,  6'd0,      1'b1, 3, 0, 0, 2, 0, -1});
        tbl.push_back('{OP_BEQ,  6'd0,      1'b0, 3, 0, 0, 1, 0, -1});
        tbl.push_back('{OP_ADDI, 6'd0,      1'b0, 4, 1, 0, 1, 0, -1});
        tbl.push_back('{OP_J,    6'd0,      1'b0, 3, 0, 0, 2, 0, -1});
        tbl.push_back('{6'b111111, 6'd0,    1'b0, 2, 0, 0, 1, 1, -1});
        tbl.push_back('{6'b010101, 6'd0,    1'b0, 2, 0, 0, 1, 1, -1});
        do_reset();
        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].funct, tbl[i].z, 0, s);
            chk($sformatf("tbl%0d_cycles", i), s.cycles, tbl[i].cyc);
            chk($sformatf("tbl%0d_seq", i), s.seq_bad + s.timeout, 0);
            chk($sformatf("tbl%0d_irwrite", i), s.irw, 1);
            chk($sformatf("tbl%0d_regwrite", i), s.rw, tbl[i].rw);
            chk($sformatf("tbl%0d_memwrite", i), s.mw, tbl[i].mw);
            chk($sformatf("tbl%0d_pcen", i), s.pcen, tbl[i].pcen);
            chk($sformatf("tbl%0d_illegal", i), s.ill, tbl[i].ill);
            if (tbl[i].alu >= 0) chk($sformatf("tbl%0d_aluctl", i), s.alu_exec, tbl[i].alu);
        end

        // lw then sw back to back: 9 cycles, lw writes from memory, sw strobes once.
        run_instr(OP_LW, 6'd0, 1'b0, 0, s);
        run_instr(OP_SW, 6'd0, 1'b0, 0, s2);
        chk("lw_sw_total_cycles", s.cycles + s2.cycles, 9);
        chk("lw_memtoreg", s.memtoreg_wb, 1);
        chk("lw_regdst", s.regdst_wb, 0);
        chk("sw_memwrite", s2.mw, 1);

        run_instr(OP_R, 6'b100010, 1'b0, 0, s);
        chk("rtype_regdst", s.regdst_wb, 1);
        run_instr(OP_BEQ, 6'd0, 1'b1, 0, s);
        chk("beq_pcsrc", s.pcsrc_beq, 1);

        // PCEn follows zero within the BEQ cycle.
        op = OP_BEQ; zero = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("beq_state", int'(ob.st), S_BEQ);
        chk("beq_pcen_z1", int'(ob.pcen), 1);
        zero = 1'b0; #1;
        chk("beq_pcen_z0_same_cycle", int'(ob.pcen), 0);
        @(posedge clk); #1;
        chk("beq_back_to_fetch", int'(ob.st), S_FETCH);

        // lw with 3 stall cycles in FETCH and in MEMRD.
        run_instr(OP_LW, 6'd0, 1'b0, 2, s);
        chk("lw_stall_cycles", s.cycles, 11);
        chk("lw_stall_irwrite", s.irw, 1);
        chk("lw_stall_regwrite", s.rw, 1);

        // Reset held 2 cycles while a store waits in MEMWR.
        op = OP_SW; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0; #1;
        chk("memwr_pre_state", int'(ob.st), S_MEMWR);
        chk("memwr_pre_memwrite", int'(ob.memwrite), 1);
        rst = 1'b1; #1;
        chk("rst_memwrite_c1", int'(ob.memwrite), 0);
        @(posedge clk); #1;
        mem_ready = 1'b1; #1;
        chk("rst_state_c2", int'(ob.st), S_FETCH);
        chk("rst_irwrite_c2", int'(ob.irwrite), 0);
        chk("rst_memwrite_c2", int'(ob.memwrite), 0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("rel_state", int'(ob.st), S_FETCH);
        chk("rel_irwrite", int'(ob.irwrite), 1);

        // EN_JUMP=0: j and 111111 both decode as illegal.
        sel = 1; do_reset();
        run_instr(OP_J, 6'd0, 1'b0, 0, s);
        run_instr(6'b111111, 6'd0, 1'b0, 0, s2);
        chk("nj_j_cycles", s.cycles, 2);
        chk("nj_j_illegal", s.ill, 1);
        chk("nj_j_illegal_in_decode", s.ill_dec, 1);
        chk("nj_j_pcen", s.pcen, 1);
        chk("nj_j_regwrite", s.rw, 0);
        chk("nj_ff_illegal", s2.ill, 1);
        chk("nj_ff_illegal_in_decode", s2.ill_dec, 1);
        chk("nj_ff_pcen", s2.pcen, 1);
        chk("nj_ff_regwrite", s2.rw, 0);

        // MEM_HS=0: mem_ready low has no effect on latency.
        sel = 2; do_reset();
        run_instr(OP_LW, 6'd0, 1'b0, 2, s);
        chk("nohs_lw_cycles", s.cycles, 5);
        run_instr(OP_SW, 6'd0, 1'b0, 2, s);
        chk("nohs_sw_cycles", s.cycles, 4);

        // Randomized instruction stream on every configuration against the model.
        for (int inst = 0; inst < 3; inst++) begin
            sel = inst; do_reset();
            for (int n = 0; n < 30; n++) begin
                kind = $urandom_range(0, 6);
                case (kind)
                    0: ro = OP_LW;
                    1: ro = OP_SW;
                    2: ro = OP_R;
                    3: ro = OP_BEQ;
                    4: ro = OP_ADDI;
                    5: ro = OP_J;
                    default: ro = 6'($urandom_range(48, 63));
                endcase
                rf = fl[$urandom_range(0, 5)];
                rz = 1'($urandom_range(0, 1));
                run_instr(ro, rf, rz, 1, s);
                lg = legal_for(ro, inst);
                exp_rw = (lg && (ro == OP_LW || ro == OP_R || ro == OP_ADDI)) ? 1 : 0;
                exp_pcen = 1 + ((ro == OP_BEQ && rz) ? 1 : 0) + ((lg && ro == OP_J) ? 1 : 0);
                chk("rnd_sequence", s.seq_bad + s.timeout + (1 - s.model_done), 0);
                chk("rnd_irwrite", s.irw, 1);
                chk("rnd_regwrite", s.rw, exp_rw);
                chk("rnd_memwrite", s.mw, s.m_mw);
                chk("rnd_pcen", s.pcen, exp_pcen);
                chk("rnd_illegal", s.ill, lg ? 0 : 1);
                if (ro == OP_R) chk("rnd_aluctl", s.alu_exec, alu_ref(rf));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
